// File: rtl/neuron_acc.sv
// Pipelined signed multiply-accumulate neuron: product, saturating accumulate, shifted/saturated output.
// Optional ReLU on the output stage when NEURON_ACC_RELU_EN is defined.
module neuron_acc #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int DOUT_WIDTH   = 16,
  parameter int DOUT_SHIFT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  sat
);

  localparam int ProdWidth = DATA_WIDTH + WEIGHT_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  // Output limits expressed at accumulator width so the compare needs no truncation.
  localparam logic signed [ACC_WIDTH-1:0] DoutMax =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DoutMin =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  // Stage 1: product register
  logic signed [ProdWidth-1:0] prod_q;
  logic                        prod_valid_q;
  logic                        prod_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
    end else begin
      prod_valid_q <= din_valid;
      prod_last_q  <= din_valid & din_last;
      if (din_valid) begin
        prod_q <= ProdWidth'($signed(din)) * ProdWidth'($signed(weight));
      end
    end
  end

  // Stage 2: saturating accumulator
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        acc_sat_q, acc_sat_d;
  logic                        first_q, first_d;
  logic                        done_q;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH:0]   sum;

  assign prod_ext = ACC_WIDTH'(prod_q);
  assign sum      = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext);

  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    first_d   = first_q;
    if (prod_valid_q) begin
      first_d = prod_last_q;
      if (first_q) begin
        acc_d     = prod_ext;
        acc_sat_d = 1'b0;
      end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        acc_d     = sum[ACC_WIDTH] ? AccMin : AccMax;
        acc_sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      first_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      first_q   <= first_d;
      done_q    <= prod_valid_q & prod_last_q;
    end
  end

  // Stage 3: shift, saturate to output width, optional ReLU
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [DOUT_WIDTH-1:0]       res;
  logic                        out_sat;
  logic [DOUT_WIDTH-1:0]       dout_q;
  logic                        dout_valid_q;
  logic                        sat_q;

  assign shifted = acc_q >>> DOUT_SHIFT;

  always_comb begin
    out_sat = 1'b0;
    res     = shifted[DOUT_WIDTH-1:0];
    if (shifted > DoutMax) begin
      res     = DoutMax[DOUT_WIDTH-1:0];
      out_sat = 1'b1;
    end else if (shifted < DoutMin) begin
      res     = DoutMin[DOUT_WIDTH-1:0];
      out_sat = 1'b1;
    end
`ifdef NEURON_ACC_RELU_EN
    if (res[DOUT_WIDTH-1]) begin
      res = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      dout_valid_q <= done_q;
      if (done_q) begin
        dout_q <= res;
        sat_q  <= acc_sat_q | out_sat;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_neuron_acc.sv
// Bench for neuron_acc: two instances (DOUT_SHIFT 0 and 2) checked every cycle against a
// vector-level arithmetic model, plus literal pins on the model's results.
module tb_neuron_acc;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        din = '0;
  logic [7:0]        weight = '0;
  logic              din_valid = 1'b0;
  logic              din_last = 1'b0;
  logic [15:0]       dout_a, dout_b;
  logic              dv_a, dv_b, sat_a, sat_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_acc #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(24), .DOUT_WIDTH(16),
               .DOUT_SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .weight(weight), .din_valid(din_valid),
    .din_last(din_last), .dout(dout_a), .dout_valid(dv_a), .sat(sat_a)
  );

  neuron_acc #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(24), .DOUT_WIDTH(16),
               .DOUT_SHIFT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .weight(weight), .din_valid(din_valid),
    .din_last(din_last), .dout(dout_b), .dout_valid(dv_b), .sat(sat_b)
  );

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int unsigned due;
    longint      da;
    longint      db;
    bit          sa;
    bit          sb;
  } exp_t;

  exp_t        q[$];
  longint      res_a[$];
  longint      res_b[$];
  bit          res_sat_a[$];
  int unsigned cyc = 0;
  longint      acc = 0;
  bit          acc_sat = 0;
  bit          first = 1;

  function automatic void out_calc(longint a, int s, output longint v, output bit os);
    v  = a >>> s;
    os = 0;
    if (v > 32767) begin
      v = 32767; os = 1;
    end else if (v < -32768) begin
      v = -32768; os = 1;
    end
`ifdef NEURON_ACC_RELU_EN
    if (v < 0) v = 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc = 0; acc_sat = 0; first = 1;
      q.delete();
    end else begin
      cyc++;
      if (din_valid) begin
        longint p;
        p = longint'($signed(din)) * longint'($signed(weight));
        if (first) begin
          acc = p; acc_sat = 0;
        end else begin
          acc = acc + p;
        end
        if (acc > 8388607) begin
          acc = 8388607; acc_sat = 1;
        end else if (acc < -8388608) begin
          acc = -8388608; acc_sat = 1;
        end
        first = din_last;
        if (din_last) begin
          exp_t e;
          bit   os;
          e.due = cyc + 2;
          out_calc(acc, 0, e.da, os); e.sa = acc_sat | os;
          out_calc(acc, 2, e.db, os); e.sb = acc_sat | os;
          q.push_back(e);
        end
      end
    end
  end

  // ---------------- compare ----------------
  longint hold_a = 0, hold_b = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      hold_a = 0; hold_b = 0;
      chk("rst_dout_valid_a", dv_a, 0);
      chk("rst_dout_a", longint'($signed(dout_a)), 0);
      chk("rst_sat_a", sat_a, 0);
      chk("rst_dout_valid_b", dv_b, 0);
      chk("rst_dout_b", longint'($signed(dout_b)), 0);
      chk("rst_sat_b", sat_b, 0);
    end else begin
      bit due;
      due = (q.size() > 0) && (q[0].due == cyc);
      chk("dout_valid_a", dv_a, longint'(due));
      chk("dout_valid_b", dv_b, longint'(due));
      if (due) begin
        hold_a = q[0].da; hold_b = q[0].db;
        chk("sat_a", sat_a, longint'(q[0].sa));
        chk("sat_b", sat_b, longint'(q[0].sb));
        res_a.push_back(q[0].da);
        res_b.push_back(q[0].db);
        res_sat_a.push_back(q[0].sa);
        void'(q.pop_front());
      end
      chk("dout_a", longint'($signed(dout_a)), hold_a);
      chk("dout_b", longint'($signed(dout_b)), hold_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(int d, int w, bit last);
    @(negedge clk);
    din = 8'(d); weight = 8'(w); din_valid = 1'b1; din_last = last;
  endtask

  task automatic bubble(int n);
    repeat (n) begin
      @(negedge clk);
      din = 8'($urandom); weight = 8'($urandom); din_valid = 1'b0; din_last = 1'($urandom);
    end
  endtask

  function automatic longint pick(longint qv[$], int idx);
    if (idx < qv.size()) return qv[idx];
    return -99999;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint neg30, neg7, neg2;
`ifdef NEURON_ACC_RELU_EN
    neg30 = 0; neg7 = 0; neg2 = 0;
`else
    neg30 = -30; neg7 = -7; neg2 = -2;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // contiguous 1*4 + 2*5 + 3*6
    send(1, 4, 0); send(2, 5, 0); send(3, 6, 1);
    bubble(5);
    // back-to-back single-sample vectors
    send(-128, -128, 1); send(10, -3, 1);
    bubble(5);
    // output saturation
    for (int i = 0; i < 4; i++) send(127, 127, i == 3);
    bubble(5);
    // bubbles between samples
    send(1, 4, 0); bubble(1); send(2, 5, 0); bubble(3); send(3, 6, 1);
    bubble(5);
    // reset mid-vector
    send(7, 7, 0); send(9, 9, 0);
    @(negedge clk); din_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(2, 2, 1);
    bubble(5);
    // negative value through the shifted instance
    send(-7, 1, 1);
    bubble(5);

    chk("lit_n_results", res_a.size(), 7);
    chk("lit_v0_a", pick(res_a, 0), 32);
    chk("lit_v0_b", pick(res_b, 0), 8);
    chk("lit_v1_a", pick(res_a, 1), 16384);
    chk("lit_v2_a", pick(res_a, 2), neg30);
    chk("lit_v3_a", pick(res_a, 3), 32767);
    chk("lit_v3_sat", (res_sat_a.size() > 3) ? longint'(res_sat_a[3]) : -1, 1);
    chk("lit_v4_a", pick(res_a, 4), 32);
    chk("lit_v5_a", pick(res_a, 5), 4);
    chk("lit_v6_a", pick(res_a, 6), neg7);
    chk("lit_v6_b", pick(res_b, 6), neg2);

    // random short vectors with random bubbles and occasional back-to-back
    for (int v = 0; v < 25; v++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             i == len - 1);
        if ($urandom_range(0, 2) == 0) bubble(int'($urandom_range(1, 3)));
      end
    end
    bubble(5);

    // accumulator saturation, both directions
    for (int i = 0; i < 600; i++) send(127, 127, i == 599);
    bubble(5);
    for (int i = 0; i < 600; i++) send(-128, 127, i == 599);
    bubble(5);
    chk("lit_accsat_pos", pick(res_a, res_a.size() - 2), 32767);
    chk("lit_accsat_neg", pick(res_b, res_b.size() - 1), 0 - (8388608 >>> 2) > -32768 ?
        0 - (8388608 >>> 2) : neg_clip());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // -2^23 >>> 2 saturates to the 16-bit negative limit (0 under ReLU)
  function automatic longint neg_clip();
`ifdef NEURON_ACC_RELU_EN
    return 0;
`else
    return -32768;
`endif
  endfunction

endmodule
